// File: rtl/ddr4_device_model.sv
// Cycle-level DDR4 device responder: per-bank open-row FSMs, word store, CL-delayed read return.
// Latency: READ sampled at edge N returns data after edge N+CL; no backpressure (illegal commands flagged, not stalled).
module ddr4_device_model #(
    parameter int BANKS    = 8,
    parameter int ROW_BITS = 8,
    parameter int COL_BITS = 4,
    parameter int TRCD     = 2,
    parameter int CL       = 3,
    parameter int TRP      = 2,
    parameter int TRFC     = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_N_in,
    input  logic                     cs_N_in,
    input  logic                     ras_N_in,
    input  logic                     cas_N_in,
    input  logic                     we_N_in,
    input  logic [$clog2(BANKS)-1:0] bank_in,
    input  logic [ROW_BITS-1:0]      addr_in,
    input  logic [63:0]              wdata_in,
    output logic                     ready_out,
    output logic [63:0]              rdata_out,
    output logic                     valid_out,
    output logic                     cmd_err_out
);
    localparam int BW   = $clog2(BANKS);
    localparam int ROWS = 1 << ROW_BITS;
    localparam int COLS = 1 << COL_BITS;
    localparam int CW   = 8;

    typedef enum logic [1:0] {B_IDLE, B_ACTIVATING, B_ACTIVE, B_PRECHARGING} bank_st_e;
    typedef enum logic [2:0] {C_NOP, C_ACT, C_RD, C_WR, C_PRE, C_REF, C_BAD} cmd_e;

    cmd_e                cmd;
    bank_st_e            st_q   [BANKS];
    bank_st_e            st_d   [BANKS];
    logic [CW-1:0]       cnt_q  [BANKS];
    logic [CW-1:0]       cnt_d  [BANKS];
    logic [ROW_BITS-1:0] row_q  [BANKS];
    logic [ROW_BITS-1:0] row_d  [BANKS];
    logic [CW-1:0]       ref_cnt_q, ref_cnt_d;
    logic [CL-1:0]       pipe_vld_q;
    logic [63:0]         pipe_dat_q [CL];
    logic                valid_q;
    logic [63:0]         rdata_q;
    logic                err_q;
    logic [63:0]         mem_q [BANKS][ROWS][COLS];

    logic                illegal, do_act, do_rd, do_wr, do_pre, do_ref;
    logic                refreshing, all_idle;
    bank_st_e            sel_st;
    logic [COL_BITS-1:0] col;
    logic [63:0]         rd_word;

    assign refreshing  = (ref_cnt_q != '0);
    assign sel_st      = st_q[bank_in];
    assign col         = addr_in[COL_BITS-1:0];
    assign rd_word     = mem_q[bank_in][row_q[bank_in]][col];
    assign ready_out   = ~refreshing;
    assign valid_out   = valid_q;
    assign rdata_out   = rdata_q;
    assign cmd_err_out = err_q;

    always_comb begin
        all_idle = 1'b1;
        for (int b = 0; b < BANKS; b++) begin
            if (st_q[b] != B_IDLE) all_idle = 1'b0;
        end
    end

    always_comb begin
        cmd = C_NOP;
        if (!cs_N_in) begin
            case ({ras_N_in, cas_N_in, we_N_in})
                3'b011:  cmd = C_ACT;
                3'b101:  cmd = C_RD;
                3'b100:  cmd = C_WR;
                3'b010:  cmd = C_PRE;
                3'b001:  cmd = C_REF;
                3'b111:  cmd = C_NOP;
                default: cmd = C_BAD;
            endcase
        end
    end

    // Legality is judged against state before the edge; an illegal command has no side effect.
    always_comb begin
        illegal = 1'b0;
        do_act  = 1'b0;
        do_rd   = 1'b0;
        do_wr   = 1'b0;
        do_pre  = 1'b0;
        do_ref  = 1'b0;
        if (refreshing && cmd != C_NOP) begin
            illegal = 1'b1;
        end else begin
            case (cmd)
                C_ACT: if (sel_st == B_IDLE) do_act = 1'b1; else illegal = 1'b1;
                C_RD:  if (sel_st == B_ACTIVE) do_rd = 1'b1; else illegal = 1'b1;
                C_WR:  if (sel_st == B_ACTIVE) do_wr = 1'b1; else illegal = 1'b1;
                C_PRE: begin
                    if (sel_st == B_ACTIVE) do_pre = 1'b1;
                    else if (sel_st != B_IDLE) illegal = 1'b1;
                end
                C_REF: if (all_idle) do_ref = 1'b1; else illegal = 1'b1;
                C_BAD: illegal = 1'b1;
                default: ;
            endcase
        end
    end

    // Countdown is loaded with T-1 so the bank is usable exactly T edges after the command.
    always_comb begin
        for (int b = 0; b < BANKS; b++) begin
            st_d[b]  = st_q[b];
            cnt_d[b] = cnt_q[b];
            row_d[b] = row_q[b];
            case (st_q[b])
                B_ACTIVATING, B_PRECHARGING: begin
                    if (cnt_q[b] <= CW'(1)) begin
                        st_d[b]  = (st_q[b] == B_ACTIVATING) ? B_ACTIVE : B_IDLE;
                        cnt_d[b] = '0;
                    end else begin
                        cnt_d[b] = cnt_q[b] - CW'(1);
                    end
                end
                default: ;
            endcase
            if (BW'(b) == bank_in) begin
                if (do_act) begin
                    row_d[b] = addr_in;
                    if (TRCD <= 1) begin
                        st_d[b] = B_ACTIVE;
                    end else begin
                        st_d[b]  = B_ACTIVATING;
                        cnt_d[b] = CW'(TRCD - 1);
                    end
                end else if (do_pre) begin
                    if (TRP <= 1) begin
                        st_d[b] = B_IDLE;
                    end else begin
                        st_d[b]  = B_PRECHARGING;
                        cnt_d[b] = CW'(TRP - 1);
                    end
                end
            end
        end
        if (do_ref)          ref_cnt_d = CW'(TRFC);
        else if (refreshing) ref_cnt_d = ref_cnt_q - CW'(1);
        else                 ref_cnt_d = ref_cnt_q;
    end

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            for (int b = 0; b < BANKS; b++) begin
                st_q[b]  <= B_IDLE;
                cnt_q[b] <= '0;
                row_q[b] <= '0;
            end
            ref_cnt_q  <= '0;
            pipe_vld_q <= '0;
            for (int i = 0; i < CL; i++) pipe_dat_q[i] <= '0;
            valid_q    <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            for (int b = 0; b < BANKS; b++) begin
                st_q[b]  <= st_d[b];
                cnt_q[b] <= cnt_d[b];
                row_q[b] <= row_d[b];
            end
            ref_cnt_q <= ref_cnt_d;
            for (int i = CL - 1; i > 0; i--) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_dat_q[i] <= pipe_dat_q[i-1];
            end
            pipe_vld_q[0] <= do_rd;
            pipe_dat_q[0] <= rd_word;
            // Output stage adds the final cycle of CL and holds data between reads.
            valid_q <= pipe_vld_q[CL-1];
            if (pipe_vld_q[CL-1]) rdata_q <= pipe_dat_q[CL-1];
            err_q <= illegal;
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_wr) mem_q[bank_in][row_q[bank_in]][col] <= wdata_in;
    end
endmodule

// File: tb/tb_ddr4_device_model.sv
// Bench for ddr4_device_model: directed protocol scenarios plus randomized commands against an edge-count model.
module tb_ddr4_device_model;
    localparam int TRCD = 2, CL = 3, TRP = 2, TRFC = 8;

    logic        clk = 1'b0;
    logic        rst_n, cs_n, ras_n, cas_n, we_n;
    logic [2:0]  bank;
    logic [7:0]  addr;
    logic [63:0] wdata;
    logic        rdy, vld, err;
    logic [63:0] rdata;

    always #5 clk = ~clk;

    ddr4_device_model #(.BANKS(8), .ROW_BITS(8), .COL_BITS(4), .TRCD(TRCD), .CL(CL), .TRP(TRP), .TRFC(TRFC)) dut (
        .clk_in(clk), .rst_N_in(rst_n), .cs_N_in(cs_n), .ras_N_in(ras_n), .cas_N_in(cas_n), .we_N_in(we_n),
        .bank_in(bank), .addr_in(addr), .wdata_in(wdata), .ready_out(rdy), .rdata_out(rdata),
        .valid_out(vld), .cmd_err_out(err));

    typedef enum int {NOP, ACT, RD, WR, PRE, REF, BAD0, BAD6, DES} cmd_t;

    int total = 0, bad = 0;

    // Reference model: bank status is kept as the edge index of its last ACT/PRE.
    bit          m_open [8];
    int          m_row  [8];
    int          m_act  [8];
    int          m_pre  [8];
    int          m_ref, ecnt;
    logic [63:0] m_mem [int];
    int          q_due [$];
    logic [63:0] q_dat [$];
    bit          q_known [$];
    logic        exp_err, exp_vld, exp_rdy;
    logic [63:0] exp_dat;
    bit          exp_dk;

    task automatic model_reset();
        for (int b = 0; b < 8; b++) begin
            m_open[b] = 0; m_row[b] = 0; m_act[b] = -100; m_pre[b] = -100;
        end
        m_ref = -100; ecnt = 0;
        q_due.delete(); q_dat.delete(); q_known.delete();
        exp_err = 0; exp_vld = 0; exp_rdy = 1; exp_dat = '0; exp_dk = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; cs_n = 1;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        model_reset();
    endtask

    task automatic issue(input cmd_t c, input int b, input int a, input logic [63:0] wd);
        int  e, key;
        bit  refr, ill, allidle;
        @(negedge clk);
        bank = 3'(b); addr = 8'(a); wdata = wd;
        case (c)
            ACT:  {cs_n, ras_n, cas_n, we_n} = 4'b0011;
            RD:   {cs_n, ras_n, cas_n, we_n} = 4'b0101;
            WR:   {cs_n, ras_n, cas_n, we_n} = 4'b0100;
            PRE:  {cs_n, ras_n, cas_n, we_n} = 4'b0010;
            REF:  {cs_n, ras_n, cas_n, we_n} = 4'b0001;
            BAD0: {cs_n, ras_n, cas_n, we_n} = 4'b0000;
            BAD6: {cs_n, ras_n, cas_n, we_n} = 4'b0110;
            DES:  {cs_n, ras_n, cas_n, we_n} = {1'b1, 3'($urandom_range(0, 7))};
            default: {cs_n, ras_n, cas_n, we_n} = 4'b0111;
        endcase
        @(posedge clk);
        e = ecnt;
        refr = (e > m_ref) && (e <= m_ref + TRFC);
        ill = 0;
        if (refr && c != NOP && c != DES) ill = 1;
        else begin
            case (c)
                ACT: if (!m_open[b] && e >= m_pre[b] + TRP) begin
                         m_open[b] = 1; m_row[b] = a; m_act[b] = e;
                     end else ill = 1;
                RD, WR: if (m_open[b] && e >= m_act[b] + TRCD) begin
                         key = (b << 12) | (m_row[b] << 4) | (a & 15);
                         if (c == WR) m_mem[key] = wd;
                         else begin
                             q_due.push_back(e + CL);
                             q_known.push_back(m_mem.exists(key));
                             q_dat.push_back(m_mem.exists(key) ? m_mem[key] : 64'h0);
                         end
                     end else ill = 1;
                PRE: if (m_open[b]) begin
                         if (e >= m_act[b] + TRCD) begin m_open[b] = 0; m_pre[b] = e; end
                         else ill = 1;
                     end else if (e < m_pre[b] + TRP) ill = 1;
                REF: begin
                         allidle = 1;
                         for (int i = 0; i < 8; i++)
                             if (m_open[i] || e < m_pre[i] + TRP) allidle = 0;
                         if (allidle) m_ref = e; else ill = 1;
                     end
                BAD0, BAD6: ill = 1;
                default: ;
            endcase
        end
        exp_err = ill;
        exp_vld = 0;
        if (q_due.size() > 0 && q_due[0] == e) begin
            exp_vld = 1;
            exp_dat = q_dat.pop_front();
            exp_dk  = q_known.pop_front();
            void'(q_due.pop_front());
        end
        exp_rdy = !((e >= m_ref) && (e < m_ref + TRFC));
        ecnt++;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", rdy); end
        total++; if (vld !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", vld); end
        total++; if (rdata !== 64'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", rdata); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    endtask

    task automatic test_act_timing();
        issue(ACT, 2, 5, 0);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL act_err got=%b want=0", err); end
        issue(RD, 2, 1, 0);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL early_read_err got=%b want=1", err); end
        issue(RD, 2, 1, 0);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL trcd_read_err got=%b want=0", err); end
        for (int k = 1; k <= CL + 1; k++) begin
            issue(NOP, 0, 0, 0);
            total++;
            if (vld !== (k == CL)) begin bad++; $display("FAIL act_timing_valid k=%0d got=%b want=%b", k, vld, k == CL); end
        end
    endtask

    task automatic test_write_read();
        logic [63:0] d = 64'hDEADBEEF_CAFEF00D;
        issue(ACT, 0, 3, 0);
        issue(NOP, 0, 0, 0);
        issue(WR, 0, 7, d);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL wr_err got=%b want=0", err); end
        issue(RD, 0, 7, 0);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rd_err got=%b want=0", err); end
        for (int k = 1; k <= CL + 2; k++) begin
            issue(NOP, 0, 0, 0);
            total++;
            if (vld !== (k == CL)) begin bad++; $display("FAIL wr_rd_valid k=%0d got=%b want=%b", k, vld, k == CL); end
            if (k >= CL) begin
                total++;
                if (rdata !== d) begin bad++; $display("FAIL wr_rd_data k=%0d got=%h want=%h", k, rdata, d); end
            end
        end
    endtask

    task automatic test_back_to_back();
        issue(ACT, 1, 9, 0);
        issue(NOP, 0, 0, 0);
        for (int c = 0; c < 4; c++) issue(WR, 1, c, 64'(16 + c));
        for (int s = 0; s < CL + 5; s++) begin
            if (s < 4) issue(RD, 1, s, 0); else issue(NOP, 0, 0, 0);
            total++;
            if (vld !== (s >= CL && s < CL + 4)) begin
                bad++; $display("FAIL b2b_valid s=%0d got=%b want=%b", s, vld, (s >= CL && s < CL + 4));
            end
            if (s >= CL && s < CL + 4) begin
                total++;
                if (rdata !== 64'(16 + s - CL)) begin
                    bad++; $display("FAIL b2b_data s=%0d got=%h want=%h", s, rdata, 64'(16 + s - CL));
                end
            end
        end
    endtask

    task automatic test_refresh();
        issue(PRE, 0, 0, 0);
        issue(PRE, 2, 0, 0);
        issue(REF, 0, 0, 0);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL ref_busy_err got=%b want=1", err); end
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL ref_busy_ready got=%b want=1", rdy); end
        issue(PRE, 1, 0, 0);
        issue(NOP, 0, 0, 0);
        issue(REF, 0, 0, 0);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL ref_err got=%b want=0", err); end
        total++; if (rdy !== 1'b0) begin bad++; $display("FAIL ref_ready0 got=%b want=0", rdy); end
        for (int k = 1; k <= TRFC + 1; k++) begin
            if (k == 2) issue(ACT, 3, 0, 0); else issue(NOP, 0, 0, 0);
            total++;
            if (rdy !== (k >= TRFC)) begin bad++; $display("FAIL ref_ready k=%0d got=%b want=%b", k, rdy, k >= TRFC); end
            if (k == 2) begin
                total++; if (err !== 1'b1) begin bad++; $display("FAIL ref_act_err got=%b want=1", err); end
            end
        end
        issue(ACT, 3, 0, 0);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL post_ref_act_err got=%b want=0", err); end
    endtask

    task automatic test_reset_midread();
        do_reset();
        issue(ACT, 4, 0, 0);
        issue(NOP, 0, 0, 0);
        issue(RD, 4, 0, 0);
        issue(NOP, 0, 0, 0);
        @(negedge clk);
        rst_n = 0; cs_n = 1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            total++; if (vld !== 1'b0) begin bad++; $display("FAIL midreset_valid k=%0d got=%b want=0", k, vld); end
        end
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        model_reset();
        issue(RD, 4, 0, 0);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL post_reset_read_err got=%b want=1", err); end
        for (int k = 0; k < CL + 1; k++) begin
            issue(NOP, 0, 0, 0);
            total++; if (vld !== 1'b0) begin bad++; $display("FAIL post_reset_valid k=%0d got=%b want=0", k, vld); end
        end
    endtask

    task automatic test_bank_indep();
        logic [63:0] d = 64'h0123_4567_89AB_CDEF;
        do_reset();
        issue(ACT, 0, 1, 0);
        issue(ACT, 1, 2, 0);
        issue(NOP, 0, 0, 0);
        issue(WR, 1, 5, d);
        issue(PRE, 0, 0, 0);
        issue(RD, 1, 5, 0);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL indep_rd1_err got=%b want=0", err); end
        issue(RD, 0, 5, 0);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL indep_rd0_err got=%b want=1", err); end
        for (int k = 1; k <= 3; k++) begin
            issue(NOP, 0, 0, 0);
            total++; if (vld !== (k == 2)) begin bad++; $display("FAIL indep_valid k=%0d got=%b want=%b", k, vld, k == 2); end
            if (k == 2) begin
                total++; if (rdata !== d) begin bad++; $display("FAIL indep_data got=%h want=%h", rdata, d); end
            end
        end
    endtask

    task automatic test_random();
        cmd_t c;
        int   r, b, a;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            r = $urandom_range(0, 99);
            if (r < 15)      c = ACT;
            else if (r < 35) c = RD;
            else if (r < 50) c = WR;
            else if (r < 66) c = PRE;
            else if (r < 70) c = REF;
            else if (r < 72) c = BAD0;
            else if (r < 74) c = BAD6;
            else if (r < 82) c = DES;
            else             c = NOP;
            b = $urandom_range(0, 3);
            a = (c == ACT) ? $urandom_range(0, 3) : $urandom_range(0, 255);
            issue(c, b, a, {$urandom(), $urandom()});
            total++; if (err !== exp_err) begin bad++; $display("FAIL rand_err n=%0d got=%b want=%b", n, err, exp_err); end
            total++; if (vld !== exp_vld) begin bad++; $display("FAIL rand_valid n=%0d got=%b want=%b", n, vld, exp_vld); end
            total++; if (rdy !== exp_rdy) begin bad++; $display("FAIL rand_ready n=%0d got=%b want=%b", n, rdy, exp_rdy); end
            if (exp_dk) begin
                total++; if (rdata !== exp_dat) begin bad++; $display("FAIL rand_data n=%0d got=%h want=%h", n, rdata, exp_dat); end
            end
        end
    endtask

    initial begin
        rst_n = 0; cs_n = 1; ras_n = 1; cas_n = 1; we_n = 1;
        bank = '0; addr = '0; wdata = '0;
        model_reset();
        test_reset();
        test_act_timing();
        test_write_read();
        test_back_to_back();
        test_refresh();
        test_reset_midread();
        test_bank_indep();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
